// File: rtl/cacheline_mem_arbiter.sv
// Arbitrates the shared physical-memory line port between the icache and dcache miss paths.
// The data side has priority; a streak counter bounds how long a waiting icache request can be passed over.
module cacheline_mem_arbiter #(
  parameter int unsigned LINE_W       = 256,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam int unsigned STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, DONE} state_e;

  state_e              state_q, state_d;
  logic [STREAK_W-1:0] streak_q;
  logic [LINE_W-1:0]   line_q;
  logic                d_req_c, force_i_c;
  logic                grant_i_c, grant_d_c, finish_c;

  assign d_req_c   = d_read | d_write;
  assign force_i_c = i_read && (streak_q == STREAK_MAX);

  // Both requesters see the single line buffer; only the owner's resp qualifies it.
  assign i_rdata = line_q;
  assign d_rdata = line_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    grant_i_c = 1'b0;
    grant_d_c = 1'b0;
    finish_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_req_c && !force_i_c) begin
          grant_d_c = 1'b1;
          state_d   = GRANT_D;
        end else if (i_read) begin
          grant_i_c = 1'b1;
          state_d   = GRANT_I;
        end
      end
      GRANT_I, GRANT_D: begin
        if (pmem_resp) begin
          finish_c = 1'b1;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command latches, line capture, completion pulses and the starvation streak.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      line_q       <= '0;
      streak_q     <= '0;
      i_resp       <= 1'b0;
      d_resp       <= 1'b0;
    end else begin
      i_resp <= 1'b0;
      d_resp <= 1'b0;
      if (grant_d_c) begin
        // A request with both read and write set is a writeback.
        pmem_read    <= ~d_write;
        pmem_write   <= d_write;
        pmem_address <= d_address;
        pmem_wdata   <= d_wdata;
        if (!i_read)                    streak_q <= '0;
        else if (streak_q != STREAK_MAX) streak_q <= streak_q + STREAK_W'(1);
      end else if (grant_i_c) begin
        pmem_read    <= 1'b1;
        pmem_write   <= 1'b0;
        pmem_address <= i_address;
        streak_q     <= '0;
      end
      if (finish_c) begin
        pmem_read  <= 1'b0;
        pmem_write <= 1'b0;
        if (pmem_read) line_q <= pmem_rdata;
        i_resp <= (state_q == GRANT_I);
        d_resp <= (state_q == GRANT_D);
      end
    end
  end

endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
// Bench for cacheline_mem_arbiter: directed scenarios plus random traffic, checked against a
// transaction-level order model, a reference line store and a latency-programmable memory.
module tb_cacheline_mem_arbiter;

  localparam int unsigned LINE_W = 256;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned MAX_D  = 4;

  typedef logic [LINE_W-1:0] line_t;
  typedef logic [ADDR_W-1:0] addr_t;
  // kind: 0 read, 1 write, 2 read+write (writeback)
  typedef struct {
    addr_t addr;
    int    kind;
    line_t wdata;
  } dtxn_t;

  logic  clk = 1'b0;
  logic  rst;
  logic  i_read, i_resp, d_read, d_write, d_resp;
  addr_t i_address, d_address, pmem_address;
  line_t i_rdata, d_rdata, d_wdata, pmem_wdata, pmem_rdata;
  logic  pmem_read, pmem_write, pmem_resp;

  int total = 0;
  int bad   = 0;
  int mem_lat = 3;

  line_t mem     [addr_t];
  line_t ref_mem [addr_t];
  addr_t iq [$];
  dtxn_t dq [$];
  int    exp_who [$];

  always #5 clk = ~clk;

  cacheline_mem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .MAX_D_STREAK(MAX_D)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  function automatic line_t dflt(input addr_t a);
    return {8{a ^ 32'h5A5A_0000}};
  endfunction

  function automatic line_t ref_get(input addr_t a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return dflt(a);
  endfunction

  function automatic line_t rand_line();
    line_t l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic dtxn_t mk_d(input addr_t a, input int k, input line_t w);
    dtxn_t t;
    t.addr = a; t.kind = k; t.wdata = w;
    return t;
  endfunction

  task automatic chk(input string tag, input line_t obs, input line_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory: holds a command for mem_lat cycles, then pulses resp; checks command stability meanwhile.
  int    mcnt;
  addr_t cap_addr;
  logic  cap_rd, cap_wr;
  line_t cap_wd;
  initial begin : mem_model
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    mcnt       = 0;
    forever begin
      tick();
      if (!rst) begin
        pmem_resp = 1'b0;
        mcnt      = 0;
      end else if (pmem_resp) begin
        pmem_resp  = 1'b0;
        pmem_rdata = rand_line();
      end else if (pmem_read || pmem_write) begin
        chk("rw_exclusive", line_t'(pmem_read & pmem_write), '0);
        if (mcnt == 0) begin
          cap_addr = pmem_address; cap_rd = pmem_read; cap_wr = pmem_write; cap_wd = pmem_wdata;
        end else begin
          chk("hold_addr", line_t'(pmem_address), line_t'(cap_addr));
          chk("hold_op", line_t'({pmem_read, pmem_write}), line_t'({cap_rd, cap_wr}));
          if (cap_wr) chk("hold_wdata", pmem_wdata, cap_wd);
        end
        mcnt++;
        if (mcnt >= mem_lat) begin
          if (pmem_write) mem[pmem_address] = pmem_wdata;
          else pmem_rdata = mem.exists(pmem_address) ? mem[pmem_address] : dflt(pmem_address);
          pmem_resp = 1'b1;
          mcnt      = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Expected grant order when both requesters re-request immediately after every resp.
  task automatic build_order();
    int nd = dq.size();
    int ni = iq.size();
    int k  = 0;
    exp_who.delete();
    while (nd > 0 || ni > 0) begin
      if (nd > 0 && (ni == 0 || k < int'(MAX_D))) begin
        exp_who.push_back(1);
        k = (ni > 0) ? k + 1 : 0;
        nd--;
      end else begin
        exp_who.push_back(0);
        k = 0;
        ni--;
      end
    end
  endtask

  task automatic present_i();
    if (iq.size() > 0) begin i_read = 1'b1; i_address = iq[0]; end
    else begin i_read = 1'b0; i_address = '0; end
  endtask

  task automatic present_d();
    if (dq.size() > 0) begin
      d_read    = (dq[0].kind != 1);
      d_write   = (dq[0].kind != 0);
      d_address = dq[0].addr;
      d_wdata   = dq[0].wdata;
    end else begin
      d_read = 1'b0; d_write = 1'b0;
    end
  endtask

  task automatic run(input int budget);
    int    cyc = 0, last_resp = -1, grant_cyc = 0, gidx = 0;
    logic  prev_cmd = 1'b0, prev_i = 1'b0, prev_d = 1'b0;
    logic [1:0] exp_op;
    line_t prev_drd;
    dtxn_t t;
    build_order();
    present_i();
    present_d();
    while ((iq.size() > 0 || dq.size() > 0) && cyc < budget) begin
      prev_drd = d_rdata;
      tick();
      cyc++;
      chk("resp_exclusive", line_t'(i_resp & d_resp), '0);
      if ((pmem_read || pmem_write) && !prev_cmd) begin
        chk("grant_gap", line_t'(cyc - last_resp), line_t'(2));
        grant_cyc = cyc;
        if (gidx >= exp_who.size()) chk("extra_grant", line_t'(gidx), line_t'(exp_who.size()));
        else if (exp_who[gidx] == 1) begin
          if (dq.size() == 0) chk("order_d", line_t'(dq.size()), line_t'(1));
          else begin
            exp_op = (dq[0].kind != 0) ? 2'b01 : 2'b10;
            chk("d_grant_addr", line_t'(pmem_address), line_t'(dq[0].addr));
            chk("d_grant_op", line_t'({pmem_read, pmem_write}), line_t'(exp_op));
            if (dq[0].kind != 0) chk("d_grant_wdata", pmem_wdata, dq[0].wdata);
            d_address = dq[0].addr + 32'h100;
            d_wdata   = ~dq[0].wdata;
          end
        end else begin
          if (iq.size() == 0) chk("order_i", line_t'(iq.size()), line_t'(1));
          else begin
            chk("i_grant_addr", line_t'(pmem_address), line_t'(iq[0]));
            chk("i_grant_op", line_t'({pmem_read, pmem_write}), line_t'(2'b10));
            i_address = iq[0] + 32'h100;
          end
        end
        gidx++;
      end
      prev_cmd = pmem_read | pmem_write;
      if (prev_i) chk("i_resp_pulse", line_t'(i_resp), '0);
      if (prev_d) chk("d_resp_pulse", line_t'(d_resp), '0);
      if (i_resp) begin
        if (iq.size() == 0) chk("i_resp_spurious", line_t'(i_resp), '0);
        else begin
          chk("latency_i", line_t'(cyc - grant_cyc), line_t'(mem_lat));
          chk("i_rdata", i_rdata, ref_get(iq[0]));
          void'(iq.pop_front());
          last_resp = cyc;
          present_i();
        end
      end
      if (d_resp) begin
        if (dq.size() == 0) chk("d_resp_spurious", line_t'(d_resp), '0);
        else begin
          t = dq.pop_front();
          chk("latency_d", line_t'(cyc - grant_cyc), line_t'(mem_lat));
          if (t.kind != 0) begin
            chk("d_wr_rdata_hold", d_rdata, prev_drd);
            ref_mem[t.addr] = t.wdata;
          end else begin
            chk("d_rdata", d_rdata, ref_get(t.addr));
          end
          last_resp = cyc;
          present_d();
        end
      end
      prev_i = i_resp;
      prev_d = d_resp;
    end
    chk("drained", line_t'(iq.size() + dq.size()), '0);
    chk("grant_count", line_t'(gidx), line_t'(exp_who.size()));
    tick();
    chk("quiet_after", line_t'({i_resp, d_resp, pmem_read, pmem_write}), '0);
  endtask

  initial begin : stim
    int nd, ni;
    rst = 1'b0;
    i_read = 1'b0; i_address = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
    repeat (3) tick();
    chk("rst_cmd", line_t'({pmem_read, pmem_write}), '0);
    chk("rst_addr", line_t'(pmem_address), '0);
    chk("rst_wdata", pmem_wdata, '0);
    chk("rst_resp", line_t'({i_resp, d_resp}), '0);
    chk("rst_rdata", i_rdata | d_rdata, '0);
    rst = 1'b1;
    repeat (2) tick();
    chk("idle_quiet", line_t'({pmem_read, pmem_write, i_resp, d_resp}), '0);

    // Lone icache read.
    mem_lat = 5;
    mem[32'h0000_1040]     = {32{8'hA5}};
    ref_mem[32'h0000_1040] = {32{8'hA5}};
    iq.push_back(32'h0000_1040);
    run(40);

    // Simultaneous requests: data side first.
    mem_lat = 2;
    iq.push_back(32'h0000_2000);
    dq.push_back(mk_d(32'h0000_3000, 0, '0));
    run(40);

    // Writeback with read+write set, then read it back.
    mem_lat = 3;
    dq.push_back(mk_d(32'h8000_0000, 2, {4{64'h1234_5678_9ABC_DEF0}}));
    dq.push_back(mk_d(32'h8000_0000, 0, '0));
    run(40);

    // Address shifted 0x100 -> 0x200 while granted must not reach memory.
    mem_lat = 6;
    dq.push_back(mk_d(32'h0000_0100, 0, '0));
    run(40);

    // Starvation bound: four D grants, then I, then D resumes.
    mem_lat = 2;
    for (int i = 0; i < 6; i++) dq.push_back(mk_d(32'h0000_5000 + 32'(i * 32), 0, '0));
    iq.push_back(32'h0000_6000);
    run(80);

    // Reset in the middle of a writeback.
    mem_lat = 4;
    d_read = 1'b0; d_write = 1'b1; d_address = 32'h0000_7000; d_wdata = rand_line();
    tick();
    chk("pre_rst_write", line_t'({pmem_read, pmem_write}), line_t'(2'b01));
    #2 rst = 1'b0;
    #1 chk("rst_async_cmd", line_t'({pmem_read, pmem_write}), '0);
    d_write = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk("post_rst_cmd", line_t'({pmem_read, pmem_write, i_resp, d_resp}), '0);
    chk("post_rst_addr", line_t'(pmem_address), '0);
    chk("post_rst_wdata", pmem_wdata, '0);
    chk("post_rst_rdata", i_rdata | d_rdata, '0);

    // Random traffic from both sides.
    for (int r = 0; r < 5; r++) begin
      mem_lat = $urandom_range(1, 6);
      nd = $urandom_range(0, 9);
      ni = $urandom_range(1, 5);
      for (int i = 0; i < nd; i++)
        dq.push_back(mk_d(32'h0000_4000 + 32'($urandom_range(0, 7) * 32),
                          int'($urandom_range(0, 2)), rand_line()));
      for (int i = 0; i < ni; i++)
        iq.push_back(32'h0001_0000 + 32'($urandom_range(0, 15) * 32));
      run((nd + ni) * (mem_lat + 4) + 20);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cacheline_mem_arbiter.md
Name: cacheline_mem_arbiter

Overview:
- Shares the single physical-memory burst port (cacheline adaptor side) between the instruction-cache miss path and the data-cache miss/writeback path of the pipelined CPU.
- Serializes 256-bit line transactions and registers all pmem-side outputs.
- Gives the data cache priority, since the MEM stage is the older instruction.
- Bounds instruction-side starvation with a streak counter.

Parameters:
LINE_W, 256, cacheline width in bits
ADDR_W, 32, address width
MAX_D_STREAK, 4, max consecutive D grants while I is waiting before I is forced

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-low reset (asserted when rst=0)
i_read  input  1  icache line read request
i_address  input  ADDR_W  icache line address
i_rdata  output  LINE_W  line returned to icache
i_resp  output  1  one-cycle completion pulse to icache
d_read  input  1  dcache line read request
d_write  input  1  dcache line writeback request
d_address  input  ADDR_W  dcache line address
d_wdata  input  LINE_W  writeback line
d_rdata  output  LINE_W  line returned to dcache
d_resp  output  1  one-cycle completion pulse to dcache
pmem_read  output  1  memory read command
pmem_write  output  1  memory write command
pmem_address  output  ADDR_W  memory address
pmem_wdata  output  LINE_W  memory write line
pmem_rdata  input  LINE_W  memory read line
pmem_resp  input  1  memory completion pulse

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; streak counter 0; address/wdata/line buffers 0. Reset mid-transaction aborts it, and pmem_read/pmem_write drop immediately. The memory side is assumed to be reset together with the arbiter.
- FSM states: IDLE, GRANT_I, GRANT_D, DONE.
- IDLE:
  - Samples requests.
  - Grants D if (d_read|d_write), unless i_read=1 and streak==MAX_D_STREAK, in which case I is granted.
  - Otherwise grants I if i_read.
  - At grant: latch address, op (read or write) and d_wdata into internal registers; next state GRANT_I or GRANT_D.
  - d_read and d_write both high: treated as write.
- GRANT_x:
  - pmem_read/pmem_write/pmem_address/pmem_wdata are driven only from the latched registers and are high from the first cycle in the state (1-cycle latency from request).
  - These outputs are held stable until pmem_resp.
  - Requester input changes after grant are ignored.
  - On pmem_resp: capture pmem_rdata into the line buffer (reads only), deassert pmem commands next cycle, go to DONE with the owner remembered.
- DONE:
  - Exactly one cycle; owner's x_resp=1 and x_rdata=buffer.
  - New requests are not sampled. A requester must drop its request in the cycle after it sees resp.
  - Next state IDLE.
  - Back-to-back throughput: one grant every (memory latency + 2) cycles minimum.
- i_rdata/d_rdata hold the last buffered line at all times; they are valid only while the matching resp is high. Write completions pulse d_resp with d_rdata unchanged.
- Streak counter:
  - Saturating, width $clog2(MAX_D_STREAK+1).
  - At a D grant: +1 if i_read=1, else cleared to 0.
  - At an I grant: cleared to 0.
- Never both i_resp and d_resp in one cycle; never pmem_read and pmem_write together.
- pmem_resp seen outside GRANT_x is ignored.

Test Plan:
- Reset: hold rst=0 mid-GRANT_D with pmem_write=1 -> pmem_write=0 same cycle; after release, state IDLE and all outputs 0.
- Lone I read: i_read=1, i_address=0x0000_1040, pmem_resp 5 cycles after pmem_read rises with pmem_rdata=0xA5..A5 -> pmem_read=1 next cycle with address 0x1040; i_resp=1 for exactly 1 cycle with i_rdata=0xA5..A5; d_resp=0 throughout.
- Simultaneous requests: i_read=1 and d_read=1 in the same cycle -> D served first; I granted in the IDLE cycle right after D's DONE; pmem_address sequence is d_address then i_address.
- Starvation bound: MAX_D_STREAK=4, i_read held, dcache re-requests immediately after every d_resp -> exactly 4 D transactions, then an I grant, then D resumes.
- Writeback: d_read=1 and d_write=1 with d_wdata=0x1234..., address 0x8000_0000 -> pmem_write=1 (not read) with that data/address; d_resp pulse; d_rdata unchanged from the prior value.
- Input stability: change d_address from 0x100 to 0x200 during GRANT_D -> pmem_address remains 0x100 until pmem_resp.
